// File: rtl/tx_slot_scheduler.sv
// TDMA transmit scheduler: slot alignment, carrier sense, bounded retry with backoff.
// Define BACKOFF_LFSR_EN for pseudo-random backoff; default is binary-exponential backoff.
module tx_slot_scheduler #(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned FRAME_SLOTS  = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned BACKOFF_BASE = 4,
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slotTick,
  input  logic                  txReq,
  input  logic [2:0]            txType,
  input  logic [WORD_WIDTH-1:0] myTimeslot,
  input  logic                  channel_clear,
  input  logic                  txDone,
  output logic                  txReady,
  output logic                  txStart,
  output logic                  txOk,
  output logic                  txFail,
  output logic [WORD_WIDTH-1:0] curSlot,
  output logic [1:0]            retryCount
);

  localparam int unsigned CNT_W = 16;
  localparam logic [2:0] TYPE_DATA = 3'b101;

  typedef enum logic [2:0] {
    StIdle, StWaitSlot, StSense, StBackoff, StTx, StWaitDone
  } state_e;

  state_e               state_q;
  logic [2:0]           type_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           retry_q;
  logic [WORD_WIDTH-1:0] slot_q;
  logic                 start_q, ok_q, fail_q;

  logic [WORD_WIDTH-1:0] slot_next;
  logic [1:0]           retry_inc;
  logic                 abort;
  logic                 attempt_fail;
  logic [CNT_W-1:0]     backoff_len;

`ifdef BACKOFF_LFSR_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;
  assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign backoff_len = CNT_W'(BACKOFF_BASE) + CNT_W'(lfsr_q[3:0]);
`else
  // Uses the post-increment retry value: first backoff is BACKOFF_BASE.
  assign backoff_len = CNT_W'(BACKOFF_BASE) << (retry_inc - 2'd1);
`endif

  always_comb begin
    slot_next = slot_q;
    if (slotTick) begin
      slot_next = (slot_q == WORD_WIDTH'(FRAME_SLOTS - 1)) ? '0 : slot_q + 1'b1;
    end
  end

  assign retry_inc    = (retry_q == 2'(MAX_RETRY)) ? retry_q : retry_q + 2'd1;
  assign abort        = (retry_inc == 2'(MAX_RETRY));
  assign attempt_fail = ((state_q == StSense) && !channel_clear) ||
                        ((state_q == StWaitDone) && !txDone &&
                         (cnt_q == CNT_W'(DONE_TIMEOUT - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      type_q  <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      slot_q  <= '0;
      start_q <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
`ifdef BACKOFF_LFSR_EN
      lfsr_q  <= 8'hA5;
`endif
    end else begin
      slot_q  <= slot_next;
      start_q <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
`ifdef BACKOFF_LFSR_EN
      lfsr_q  <= {lfsr_q[6:0], lfsr_fb};
`endif
      case (state_q)
        StIdle: begin
          if (txReq) begin
            type_q  <= txType;
            retry_q <= '0;
            cnt_q   <= '0;
            state_q <= (txType == TYPE_DATA) ? StWaitSlot : StSense;
          end
        end
        StWaitSlot: begin
          if (myTimeslot >= WORD_WIDTH'(FRAME_SLOTS)) begin
            fail_q  <= 1'b1;
            state_q <= StIdle;
          end else if (slotTick && (slot_next == myTimeslot)) begin
            state_q <= StSense;
          end
        end
        StSense: begin
          if (channel_clear) begin
            start_q <= 1'b1;
            state_q <= StTx;
          end
        end
        StBackoff: begin
          if (cnt_q == '0) begin
            state_q <= (type_q == TYPE_DATA) ? StWaitSlot : StSense;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StTx: begin
          cnt_q   <= '0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (txDone) begin
            ok_q    <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Busy channel and radio timeout share the same retry/abort path.
      if (attempt_fail) begin
        retry_q <= retry_inc;
        if (abort) begin
          fail_q  <= 1'b1;
          state_q <= StIdle;
        end else begin
          cnt_q   <= backoff_len - 1'b1;
          state_q <= StBackoff;
        end
      end
    end
  end

  assign txReady    = (state_q == StIdle);
  assign txStart    = start_q;
  assign txOk       = ok_q;
  assign txFail     = fail_q;
  assign curSlot    = slot_q;
  assign retryCount = retry_q;

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Directed bench for tx_slot_scheduler: vector table plus multi-cycle sequences.
module tb_tx_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slotTick = 1'b0;
  logic        txReq = 1'b0;
  logic [2:0]  txType = 3'b000;
  logic [15:0] myTimeslot = 16'd3;
  logic        channel_clear = 1'b0;
  logic        txDone = 1'b0;
  logic        txReady, txStart, txOk, txFail;
  logic [15:0] curSlot;
  logic [1:0]  retryCount;

  int checks = 0;
  int errors = 0;

  tx_slot_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .slotTick     (slotTick),
    .txReq        (txReq),
    .txType       (txType),
    .myTimeslot   (myTimeslot),
    .channel_clear(channel_clear),
    .txDone       (txDone),
    .txReady      (txReady),
    .txStart      (txStart),
    .txOk         (txOk),
    .txFail       (txFail),
    .curSlot      (curSlot),
    .retryCount   (retryCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tick, req;
    logic [2:0] typ;
    logic       clr, done;
    logic       rdy, start, ok, fail;
    logic [15:0] slot;
    logic [1:0] retry;
  } vec_t;

  vec_t vecs[23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    slotTick = 1'b0; txReq = 1'b0; txType = 3'b000; txDone = 1'b0; channel_clear = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (txOk && txFail) begin
      errors++;
      $display("FAIL ok_fail_exclusive: got ok=1 fail=1 expected not both");
    end
  end

  initial begin
    int r1, r2, r3, nstart, failat;
    int starts[3];

    //           tick req typ     clr done rdy st ok fl slot   retry
    vecs[0]  = '{0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 16'd0, 2'd0};
    vecs[1]  = '{0, 0, 3'b000, 1, 0, 0, 1, 0, 0, 16'd0, 2'd0};
    vecs[2]  = '{0, 1, 3'b000, 1, 1, 0, 0, 0, 0, 16'd0, 2'd0};
    vecs[3]  = '{1, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd1, 2'd0};
    vecs[4]  = '{0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd1, 2'd0};
    vecs[5]  = '{0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd1, 2'd0};
    vecs[6]  = '{0, 0, 3'b000, 1, 1, 1, 0, 1, 0, 16'd1, 2'd0};
    vecs[7]  = '{0, 0, 3'b000, 1, 0, 1, 0, 0, 0, 16'd1, 2'd0};
    vecs[8]  = '{0, 0, 3'b000, 1, 1, 1, 0, 0, 0, 16'd1, 2'd0};
    vecs[9]  = '{0, 1, 3'b110, 0, 0, 0, 0, 0, 0, 16'd1, 2'd0};
    vecs[10] = '{0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 16'd1, 2'd1};
    vecs[11] = '{0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd1, 2'd1};
    vecs[12] = '{1, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd2, 2'd1};
    vecs[13] = '{0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd2, 2'd1};
    vecs[14] = '{0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd2, 2'd1};
    vecs[15] = '{0, 0, 3'b000, 1, 0, 0, 1, 0, 0, 16'd2, 2'd1};
    vecs[16] = '{0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd2, 2'd1};
    vecs[17] = '{0, 0, 3'b000, 1, 1, 1, 0, 1, 0, 16'd2, 2'd1};
    vecs[18] = '{0, 0, 3'b000, 1, 0, 1, 0, 0, 0, 16'd2, 2'd1};
    vecs[19] = '{0, 1, 3'b000, 1, 0, 0, 0, 0, 0, 16'd2, 2'd0};
    vecs[20] = '{0, 0, 3'b000, 1, 0, 0, 1, 0, 0, 16'd2, 2'd0};
    vecs[21] = '{0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 16'd2, 2'd0};
    vecs[22] = '{0, 0, 3'b000, 1, 1, 1, 0, 1, 0, 16'd2, 2'd0};

    // Reset state
    step();
    chk("reset_state", 32'({txReady, txStart, txOk, txFail, curSlot, retryCount}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0}));
    rst = 1'b0;

`ifndef BACKOFF_LFSR_EN
    for (int i = 0; i < 23; i++) begin
      slotTick = vecs[i].tick; txReq = vecs[i].req; txType = vecs[i].typ;
      channel_clear = vecs[i].clr; txDone = vecs[i].done;
      step();
      chk($sformatf("vec%0d", i),
          32'({txReady, txStart, txOk, txFail, curSlot, retryCount}),
          32'({vecs[i].rdy, vecs[i].start, vecs[i].ok, vecs[i].fail, vecs[i].slot,
               vecs[i].retry}));
    end
`endif

    // Data request waits for its slot
    do_reset();
    myTimeslot = 16'd3; txType = 3'b101; txReq = 1'b1; channel_clear = 1'b1;
    step();
    txReq = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      chk($sformatf("data_nostart_%0d", t), 32'(txStart), 32'd0);
      slotTick = 1'b1;
      step();
      slotTick = 1'b0;
      chk($sformatf("data_tick_%0d", t), 32'({txStart, curSlot}), 32'({1'b0, 16'(t + 1)}));
    end
    step();
    chk("data_start", 32'({txStart, txReady}), 32'({1'b1, 1'b0}));

    // Busy channel: two backoffs, then abort
    do_reset();
    channel_clear = 1'b0; txType = 3'b000; txReq = 1'b1;
    step();
    txReq = 1'b0;
    r1 = -1; r2 = -1; r3 = -1; nstart = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (txStart) nstart++;
      if (retryCount == 2'd1 && r1 < 0) r1 = i;
      if (retryCount == 2'd2 && r2 < 0) r2 = i;
      if (txFail) begin
        r3 = i;
        break;
      end
    end
    chk("busy_first_retry", 32'(r1), 32'd1);
    chk("busy_nostart", 32'(nstart), 32'd0);
    chk("busy_fail_retry3", 32'({r3 > 0, retryCount}), 32'({1'b1, 2'd3}));
`ifdef BACKOFF_LFSR_EN
    chk("busy_lfsr_l1_range", 32'((r2 - r1 - 1 >= 4) && (r2 - r1 - 1 <= 19)), 32'd1);
    chk("busy_lfsr_l2_range", 32'((r3 - r2 - 1 >= 4) && (r3 - r2 - 1 <= 19)), 32'd1);
`else
    chk("busy_backoff_4", 32'(r2 - r1), 32'd5);
    chk("busy_backoff_8", 32'(r3 - r2), 32'd9);
`endif
    step();
    step();
    chk("retry_hold_idle", 32'({txReady, retryCount}), 32'({1'b1, 2'd3}));
    txReq = 1'b1; channel_clear = 1'b1;
    step();
    txReq = 1'b0;
    chk("retry_cleared", 32'(retryCount), 32'd0);

    // Radio silent: three launches, each after a full timeout
    do_reset();
    channel_clear = 1'b1; txType = 3'b000; txReq = 1'b1;
    step();
    txReq = 1'b0;
    nstart = 0; failat = -1;
    starts[0] = -1; starts[1] = -1; starts[2] = -1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (txStart) begin
        if (nstart < 3) starts[nstart] = i;
        nstart++;
      end
      if (txFail) begin
        failat = i;
        break;
      end
    end
    chk("silent_starts", 32'(nstart), 32'd3);
    chk("silent_fail_seen", 32'({failat > 0, retryCount}), 32'({1'b1, 2'd3}));
`ifndef BACKOFF_LFSR_EN
    chk("silent_start0", 32'(starts[0]), 32'd1);
    chk("silent_start1", 32'(starts[1]), 32'd71);
    chk("silent_start2", 32'(starts[2]), 32'd145);
    chk("silent_failat", 32'(failat), 32'd210);
`endif

    // Bad slot number
    do_reset();
    myTimeslot = 16'd9; txType = 3'b101; txReq = 1'b1;
    step();
    txReq = 1'b0;
    chk("badslot_wait", 32'({txReady, txFail}), 32'({1'b0, 1'b0}));
    step();
    chk("badslot_fail", 32'({txReady, txFail}), 32'({1'b1, 1'b1}));
    step();
    chk("badslot_pulse_end", 32'(txFail), 32'd0);

    // Reset during WAIT_DONE
    do_reset();
    myTimeslot = 16'd3; channel_clear = 1'b1; txType = 3'b000; txReq = 1'b1;
    step();
    txReq = 1'b0;
    step();
    chk("rst_prep_start", 32'(txStart), 32'd1);
    step();
    rst = 1'b1; txDone = 1'b1;
    #1;
    chk("rst_async", 32'({txReady, txStart, txOk, txFail}), 32'(4'b1000));
    step();
    chk("rst_no_ok", 32'({txReady, txOk, txFail}), 32'(3'b100));
    txDone = 1'b0;
    rst = 1'b0;

    // Reset wins over a simultaneous request
    txReq = 1'b1; rst = 1'b1;
    step();
    chk("rst_vs_req", 32'(txReady), 32'd1);
    txReq = 1'b0; rst = 1'b0;
    step();
    chk("rst_vs_req_idle", 32'(txReady), 32'd1);

    // Slot counter wraps after a frame
    do_reset();
    for (int i = 0; i < 8; i++) begin
      slotTick = 1'b1;
      step();
      chk($sformatf("wrap_%0d", i), 32'(curSlot), 32'((i + 1) % 8));
    end
    slotTick = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
